// File: rtl/dpmem_pkg.sv
// Shared types and default parameters for the param_dpmem memory slice.
package dpmem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_ADDR_W  = 10;
    localparam int unsigned DEF_DEPTH   = 1024;
    localparam int unsigned DEF_OUT_REG = 0;

endpackage

// File: rtl/dpmem_bank.sv
// Storage array with byte-enable writes and a registered, read-first read port.
module dpmem_bank
    import dpmem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     wr_adr,
    input  logic [DATA_W-1:0]     wr_dat,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     rd_adr,
    output logic [DATA_W-1:0]     rd_dat
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_dat_q;

    // Addresses are range-checked by the caller; the read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) begin
                    mem[wr_adr][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
        if (re) begin
            rd_dat_q <= mem[rd_adr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/param_dpmem.sv
// Dual-port memory with zero-fill init sweep, range checks and optional output register.
// Define DPMEM_RDW_BYPASS_EN for write-first (merged) same-address read-during-write.
module param_dpmem
    import dpmem_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned OUT_REG = DEF_OUT_REG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]     wr_adr,
    input  logic [DATA_W-1:0]     dat_in,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_adr,
    output logic [DATA_W-1:0]     dat_out,
    output logic                  rd_vld,
    output logic                  busy
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              vld1_q, vld1_d;
    logic              zero1_q, zero1_d;

    logic              wr_ok, rd_acc, rd_hit;
    logic              bank_we;
    logic [BE_W-1:0]   bank_be;
    logic [ADDR_W-1:0] bank_wadr;
    logic [DATA_W-1:0] bank_din, bank_rdata, res1;

    always_comb begin
        wr_ok  = (state_q == READY) && wr_en && (32'(wr_adr) < DEPTH);
        rd_acc = (state_q == READY) && rd_en;
        rd_hit = rd_acc && (32'(rd_adr) < DEPTH);
        if (state_q == INIT) begin
            bank_we   = 1'b1;
            bank_be   = '1;
            bank_wadr = cnt_q;
            bank_din  = '0;
        end else begin
            bank_we   = wr_ok;
            bank_be   = wr_be;
            bank_wadr = wr_adr;
            bank_din  = dat_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (32'(cnt_q) == DEPTH - 1) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = READY;
        endcase
        busy_d  = (state_d == INIT);
        vld1_d  = rd_acc;
        // Zero flag is held with the bank data so dat_out keeps its last value.
        zero1_d = rd_acc ? !rd_hit : zero1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            vld1_q  <= 1'b0;
            zero1_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            vld1_q  <= vld1_d;
            zero1_q <= zero1_d;
        end
    end

    dpmem_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk    (clk),
        .we     (bank_we),
        .be     (bank_be),
        .wr_adr (bank_wadr),
        .wr_dat (bank_din),
        .re     (rd_hit),
        .rd_adr (rd_adr),
        .rd_dat (bank_rdata)
    );

`ifdef DPMEM_RDW_BYPASS_EN
    logic [BE_W-1:0]   byp_be_q, byp_be_d;
    logic [DATA_W-1:0] byp_dat_q, byp_dat_d;

    always_comb begin
        byp_be_d  = byp_be_q;
        byp_dat_d = byp_dat_q;
        if (rd_acc) begin
            byp_be_d  = (wr_ok && (wr_adr == rd_adr)) ? wr_be : '0;
            byp_dat_d = dat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            byp_be_q  <= '0;
            byp_dat_q <= '0;
        end else begin
            byp_be_q  <= byp_be_d;
            byp_dat_q <= byp_dat_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < BE_W; i++) begin
            res1[8*i +: 8] = byp_be_q[i] ? byp_dat_q[8*i +: 8] : bank_rdata[8*i +: 8];
        end
        if (zero1_q) begin
            res1 = '0;
        end
    end
`else
    always_comb begin
        res1 = zero1_q ? '0 : bank_rdata;
    end
`endif

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] dat2_q, dat2_d;
            logic              vld2_q, vld2_d;

            always_comb begin
                dat2_d = vld1_q ? res1 : dat2_q;
                vld2_d = vld1_q;
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    dat2_q <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    dat2_q <= dat2_d;
                    vld2_q <= vld2_d;
                end
            end

            assign dat_out = dat2_q;
            assign rd_vld  = vld2_q;
        end else begin : g_no_out_reg
            assign dat_out = res1;
            assign rd_vld  = vld1_q;
        end
    endgenerate

    assign busy = busy_q;

endmodule

// File: tb/tb_param_dpmem.sv
// Bench for param_dpmem: default instance plus DEPTH=1000/OUT_REG=1 instance on shared stimulus.
module tb_param_dpmem;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, wr_en, rd_en;
    logic [1:0]  wr_be;
    logic [9:0]  wr_adr, rd_adr;
    logic [15:0] dat_in;
    logic [15:0] dout0, dout1;
    logic        vld0, vld1, busy0, busy1;

    param_dpmem dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_be(wr_be), .wr_adr(wr_adr),
        .dat_in(dat_in), .rd_en(rd_en), .rd_adr(rd_adr),
        .dat_out(dout0), .rd_vld(vld0), .busy(busy0)
    );

    param_dpmem #(.DATA_W(16), .ADDR_W(10), .DEPTH(1000), .OUT_REG(1)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_be(wr_be), .wr_adr(wr_adr),
        .dat_in(dat_in), .rd_en(rd_en), .rd_adr(rd_adr),
        .dat_out(dout1), .rd_vld(vld1), .busy(busy1)
    );

`ifdef DPMEM_RDW_BYPASS_EN
    localparam bit          BYPASS  = 1'b1;
    localparam logic [15:0] RDW_EXP = 16'h000A;
`else
    localparam bit          BYPASS  = 1'b0;
    localparam logic [15:0] RDW_EXP = 16'h0007;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, remaining sweep cycles and a result schedule.
    int unsigned dep [2] = '{1024, 1000};
    int unsigned lat [2] = '{0, 1};
    logic [15:0] mem [2][1024];
    int unsigned init_left [2];
    bit          sv [2][4];
    logic [15:0] sd [2][4];
    bit          exp_vld [2];
    logic [15:0] exp_dat [2];
    bit          exp_busy [2];
    bit          model_on = 1'b0;
    int unsigned cyc = 0;

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] be);
        logic [15:0] r;
        r[7:0]  = be[0] ? new_w[7:0]  : old_w[7:0];
        r[15:8] = be[1] ? new_w[15:8] : old_w[15:8];
        return r;
    endfunction

    always @(posedge clk) begin
        logic [15:0] r;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                init_left[d] = dep[d];
                for (int s = 0; s < 4; s++) sv[d][s] = 1'b0;
                exp_dat[d] = 16'h0000;
                for (int a = 0; a < 1024; a++) mem[d][a] = 16'h0000;
            end else if (init_left[d] > 0) begin
                init_left[d]--;
            end else begin
                if (rd_en) begin
                    r = 16'h0000;
                    if (rd_adr < dep[d]) begin
                        r = mem[d][rd_adr];
                        if (BYPASS && wr_en && wr_adr == rd_adr)
                            r = merge(r, dat_in, wr_be);
                    end
                    sv[d][(cyc + lat[d]) % 4] = 1'b1;
                    sd[d][(cyc + lat[d]) % 4] = r;
                end
                if (wr_en && wr_adr < dep[d])
                    mem[d][wr_adr] = merge(mem[d][wr_adr], dat_in, wr_be);
            end
            if (sv[d][cyc % 4]) begin
                exp_vld[d] = 1'b1;
                exp_dat[d] = sd[d][cyc % 4];
                sv[d][cyc % 4] = 1'b0;
            end else begin
                exp_vld[d] = 1'b0;
            end
            exp_busy[d] = (init_left[d] != 0);
        end
        if (!reset) model_on = 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy0", 32'(busy0), 32'(exp_busy[0]));
            chk("rd_vld0", 32'(vld0), 32'(exp_vld[0]));
            chk("dat_out0", 32'(dout0), 32'(exp_dat[0]));
            chk("busy1", 32'(busy1), 32'(exp_busy[1]));
            chk("rd_vld1", 32'(vld1), 32'(exp_vld[1]));
            chk("dat_out1", 32'(dout1), 32'(exp_dat[1]));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; wr_be = 2'b00;
    endtask

    // Counts sampled cycles with busy high from the current negedge, bounded.
    task automatic count_busy(output int unsigned n0, output int unsigned n1,
                              output int unsigned vld_in_init);
        int unsigned i;
        n0 = 0; n1 = 0; vld_in_init = 0;
        for (i = 0; i < 2000; i++) begin
            if (!busy0 && !busy1) break;
            if (busy0) n0++;
            if (busy1) n1++;
            if ((busy0 && vld0) || (busy1 && vld1)) vld_in_init++;
            tick();
        end
        if (i >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: busy0=%0b busy1=%0b still high after 2000 cycles", busy0, busy1);
        end
    endtask

    initial begin
        int unsigned n0, n1, nv;
        reset = 1'b0; idle(); wr_adr = '0; rd_adr = '0; dat_in = '0;
        repeat (3) tick();
        chk("reset_busy0", 32'(busy0), 32'd1);
        chk("reset_dout1", 32'(dout1), 32'd0);

        reset = 1'b1; rd_en = 1'b1; rd_adr = 10'd5;
        count_busy(n0, n1, nv);
        chk("sweep_len0", n0, 32'd1024);
        chk("sweep_len1", n1, 32'd1000);
        chk("sweep_no_vld", nv, 32'd0);
        idle(); tick(); tick();

        rd_en = 1'b1; rd_adr = 10'd5; tick(); idle();
        chk("rd5_vld0", 32'(vld0), 32'd1);
        chk("rd5_dat0", 32'(dout0), 32'h0000);
        chk("rd5_vld1_early", 32'(vld1), 32'd0);
        tick();
        chk("rd5_vld1", 32'(vld1), 32'd1);
        chk("rd5_vld0_once", 32'(vld0), 32'd0);

        wr_en = 1'b1; wr_be = 2'b11; wr_adr = 10'd1; dat_in = 16'h1234; tick();
        wr_be = 2'b01; dat_in = 16'h00AB; tick();
        idle(); rd_en = 1'b1; rd_adr = 10'd1; tick(); idle();
        chk("be_merge0", 32'(dout0), 32'h12AB);
        tick();
        chk("be_merge1", 32'(dout1), 32'h12AB);

        wr_en = 1'b1; wr_be = 2'b11; wr_adr = 10'd1; dat_in = 16'h0007; tick();
        dat_in = 16'h000A; rd_en = 1'b1; rd_adr = 10'd1; tick(); idle();
        chk("rdw0", 32'(dout0), 32'(RDW_EXP));
        tick();
        chk("rdw1", 32'(dout1), 32'(RDW_EXP));

        wr_en = 1'b1; wr_be = 2'b11; wr_adr = 10'd1010; dat_in = 16'hFFFF; tick();
        idle(); rd_en = 1'b1; rd_adr = 10'd1010; tick(); idle();
        chk("oor_ref0", 32'(dout0), 32'hFFFF);
        tick();
        chk("oor_vld1", 32'(vld1), 32'd1);
        chk("oor_dat1", 32'(dout1), 32'h0000);
        rd_en = 1'b1; rd_adr = 10'd10; tick(); idle(); tick();
        chk("no_alias1", 32'(dout1), 32'h0000);

        reset = 1'b0; tick(); reset = 1'b1;
        repeat (300) tick();
        reset = 1'b0; tick(); reset = 1'b1;
        count_busy(n0, n1, nv);
        chk("restart_len0", n0, 32'd1024);
        chk("restart_len1", n1, 32'd1000);

        rd_en = 1'b1; rd_adr = 10'd1; tick();
        rd_en = 1'b0; reset = 1'b0; tick();
        chk("flush_vld0", 32'(vld0), 32'd0);
        chk("flush_vld1", 32'(vld1), 32'd0);
        tick();
        chk("flush_vld1_late", 32'(vld1), 32'd0);
        reset = 1'b1;
        count_busy(n0, n1, nv);

        for (int i = 0; i < 3000; i++) begin
            int unsigned p;
            reset  = ($urandom_range(0, 1499) != 0);
            wr_en  = $urandom_range(0, 1) != 0;
            wr_be  = 2'($urandom_range(0, 3));
            dat_in = 16'($urandom);
            p = $urandom_range(0, 9);
            wr_adr = (p < 7) ? 10'($urandom_range(0, 7)) :
                     (p < 9) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(995, 1023));
            rd_en  = $urandom_range(0, 2) != 0;
            p = $urandom_range(0, 9);
            rd_adr = (p < 3) ? wr_adr :
                     (p < 8) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(990, 1023));
            tick();
        end
        idle(); reset = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
